// File: rtl/mult_pkg.sv
// Shared constants and types for the sequential 8x8 multiplier controller.
package mult_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned PP_W   = 8;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned STEPS  = 4;
  localparam int unsigned STEP_W = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    MUL  = ST_MUL,
    DONE = ST_DONE
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } operands_t;

endpackage

// File: rtl/mult8_seq_ctrl_wallace4.sv
// 4x4 unsigned Wallace-tree multiplier: two carry-save layers, one final adder.
module mult8_seq_ctrl_wallace4
  import mult_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  output logic [PP_W-1:0]  p
);

  logic [PP_W-1:0] pp0, pp1, pp2, pp3;
  logic [PP_W-1:0] s1, c1, s2, c2;

  // Partial product rows; the full 4x4 result always fits in 8 bits.
  assign pp0 = PP_W'({4'b0, x & {NIB_W{y[0]}}});
  assign pp1 = PP_W'({4'b0, x & {NIB_W{y[1]}}}) << 1;
  assign pp2 = PP_W'({4'b0, x & {NIB_W{y[2]}}}) << 2;
  assign pp3 = PP_W'({4'b0, x & {NIB_W{y[3]}}}) << 3;

  assign s1 = pp0 ^ pp1 ^ pp2;
  assign c1 = ((pp0 & pp1) | (pp0 & pp2) | (pp1 & pp2)) << 1;
  assign s2 = s1 ^ c1 ^ pp3;
  assign c2 = ((s1 & c1) | (s1 & pp3) | (c1 & pp3)) << 1;
  assign p  = s2 + c2;

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier: one shared 4x4 core, four nibble steps,
// valid/ready on both sides and optional zero-operand bypass.
module mult8_seq_ctrl
  import mult_pkg::*;
#(
  parameter bit ZERO_SKIP = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
);

  state_e              state_q, state_d;
  operands_t           ops_q;
  logic [PROD_W-1:0]   acc_q;
  logic [STEP_W-1:0]   step_q;
  logic                skip_q;
  logic [NIB_W-1:0]    nib_a, nib_b;
  logic [PP_W-1:0]     pp;
  logic [PROD_W-1:0]   pp_ext;
  logic [PROD_W-1:0]   acc_sum;
  logic                accept;
  logic                last_step;

  // Step bit 0 picks the a nibble, bit 1 the b nibble; shift is 4 per high nibble.
  assign nib_a   = step_q[0] ? ops_q.a[7:4] : ops_q.a[3:0];
  assign nib_b   = step_q[1] ? ops_q.b[7:4] : ops_q.b[3:0];
  assign pp_ext  = PROD_W'(pp) << (PROD_W'(step_q[0]) * 4 + PROD_W'(step_q[1]) * 4);
  assign acc_sum = acc_q + pp_ext;

  assign accept    = in_valid & in_ready;
  assign last_step = (step_q == STEP_W'(STEPS - 1));

  mult8_seq_ctrl_wallace4 u_core (
    .x (nib_a),
    .y (nib_b),
    .p (pp)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MUL;
      MUL:     if (skip_q || last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ops_q     <= '0;
      acc_q     <= '0;
      step_q    <= '0;
      skip_q    <= 1'b0;
      product   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
      if (state_q == IDLE && accept) begin
        ops_q  <= '{a: a, b: b};
        acc_q  <= '0;
        step_q <= '0;
        skip_q <= ZERO_SKIP && ((a == '0) || (b == '0));
      end else if (state_q == MUL) begin
        acc_q  <= acc_sum;
        // Counter returns to zero whenever MUL is left, including the bypass exit.
        step_q <= (state_d == DONE) ? '0 : step_q + STEP_W'(1);
        if (state_d == DONE) product <= skip_q ? '0 : acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Bench for mult8_seq_ctrl: two instances (ZERO_SKIP=0/1), latency-based model.
module tb_mult8_seq_ctrl;
  import mult_pkg::*;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv[N], ordy[N], ir[N], ov[N], bz[N];
  logic [7:0]  av[N], bv[N];
  logic [15:0] pr[N];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult8_seq_ctrl #(.ZERO_SKIP(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .b(bv[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .product(pr[0]), .busy(bz[0]));

  mult8_seq_ctrl #(.ZERO_SKIP(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .product(pr[1]), .busy(bz[1]));

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%h want=%h", nm, d, $time, act, exp);
    end
  endtask

  // Model: a job is a countdown from accept to result, then a hold until taken.
  logic        m_ir[N], m_ov[N], m_bz[N];
  logic [15:0] m_pr[N], m_pend[N];
  int          m_cnt[N];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < N; d++) begin
      if (!rst_n) begin
        m_ir[d] <= 1'b1; m_ov[d] <= 1'b0; m_bz[d] <= 1'b0;
        m_pr[d] <= '0;   m_pend[d] <= '0; m_cnt[d] <= 0;
      end else if (m_ov[d]) begin
        if (ordy[d]) begin
          m_ov[d] <= 1'b0; m_bz[d] <= 1'b0; m_ir[d] <= 1'b1;
        end
      end else if (m_ir[d]) begin
        if (iv[d]) begin
          m_ir[d]   <= 1'b0;
          m_bz[d]   <= 1'b1;
          m_pend[d] <= 16'(av[d]) * 16'(bv[d]);
          m_cnt[d]  <= (d == 1 && (av[d] == 8'd0 || bv[d] == 8'd0)) ? 1 : int'(STEPS);
        end
      end else begin
        m_cnt[d] <= m_cnt[d] - 1;
        if (m_cnt[d] == 1) begin
          m_ov[d] <= 1'b1;
          m_pr[d] <= m_pend[d];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      chk("in_ready", d, 32'(ir[d]), 32'(m_ir[d]));
      chk("out_valid", d, 32'(ov[d]), 32'(m_ov[d]));
      chk("busy", d, 32'(bz[d]), 32'(m_bz[d]));
      chk("product", d, 32'(pr[d]), 32'(m_pr[d]));
    end
  end

  // One transaction with literal expectations on latency and result.
  task automatic op(input int d, input logic [7:0] x, input logic [7:0] y, input int hold,
                    input logic [15:0] exp, input int exp_lat, input bit intrude);
    int lat;
    @(posedge clk); #1;
    iv[d] = 1'b1; av[d] = x; bv[d] = y;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    if (intrude) begin
      iv[d] = 1'b1; av[d] = 8'h05; bv[d] = 8'h07;
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ov[d] && lat < 20);
    iv[d] = 1'b0;
    chk("latency", d, 32'(lat), 32'(exp_lat));
    chk("result", d, 32'(pr[d]), 32'(exp));
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", d, 32'(ov[d]), 32'd1);
      chk("hold_product", d, 32'(pr[d]), 32'(exp));
    end
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    chk("idle_busy", d, 32'(bz[d]), 32'd0);
    chk("idle_ready", d, 32'(ir[d]), 32'd1);
    chk("kept_product", d, 32'(pr[d]), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < N; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; av[d] = '0; bv[d] = '0;
    end
    repeat (2) @(posedge clk);
    #3;
    for (int d = 0; d < N; d++) begin
      chk("rst_ready", d, 32'(ir[d]), 32'd1);
      chk("rst_valid", d, 32'(ov[d]), 32'd0);
      chk("rst_busy", d, 32'(bz[d]), 32'd0);
      chk("rst_product", d, 32'(pr[d]), 32'd0);
    end
    rst_n = 1'b1;

    op(0, 8'hFF, 8'hFF, 0, 16'hFE01, 4, 1'b0);
    op(0, 8'h12, 8'h34, 3, 16'h03A8, 4, 1'b0);
    op(0, 8'h12, 8'h34, 0, 16'h03A8, 4, 1'b1);
    op(0, 8'h05, 8'h07, 1, 16'h0023, 4, 1'b0);
    op(0, 8'h00, 8'h9A, 0, 16'h0000, 4, 1'b0);
    op(1, 8'h00, 8'h9A, 0, 16'h0000, 1, 1'b0);
    op(1, 8'h9A, 8'h00, 2, 16'h0000, 1, 1'b0);
    op(1, 8'hFF, 8'hFF, 0, 16'hFE01, 4, 1'b0);
    op(1, 8'h80, 8'h01, 0, 16'h0080, 4, 1'b0);
    op(0, 8'h0F, 8'hF0, 0, 16'h0E10, 4, 1'b0);

    // Abort mid-operation: accept, let steps 0 and 1 complete, reset in step 2.
    @(posedge clk); #1;
    iv[0] = 1'b1; av[0] = 8'hFF; bv[0] = 8'hFF;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 0, 32'(ov[0]), 32'd0);
    chk("abort_product", 0, 32'(pr[0]), 32'd0);
    chk("abort_busy", 0, 32'(bz[0]), 32'd0);
    chk("abort_ready", 0, 32'(ir[0]), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("no_stale_valid", 0, 32'(ov[0]), 32'd0);
    end
    op(0, 8'h12, 8'h34, 0, 16'h03A8, 4, 1'b0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
